// File: rtl/hazard_stall_controller.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, data-memory wait freezes, saturating perf counters and a sticky timeout.
module hazard_stall_controller #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IDRs1_i,
    input  logic [4:0]       IDRs2_i,
    input  logic             IDUsesRs1_i,
    input  logic             IDUsesRs2_i,
    input  logic             EXMemRead_i,
    input  logic [4:0]       EXRd_i,
    input  logic             IDBranchTaken_i,
    input  logic             MEMMemRead_i,
    input  logic             MEMMemWrite_i,
    input  logic             DMemAck_i,
    output logic             DMemReq_o,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFIDFlush_o,
    output logic             NoOp_o,
    output logic             Stall_o,
    output logic             Timeout_o,
    output logic [CNT_W-1:0] StallCycles_o,
    output logic [CNT_W-1:0] BubbleCount_o,
    output logic [CNT_W-1:0] FlushCount_o,
    output logic [0:0]       FsmState_o
);
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MEMWAIT = 1'b1;
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]       state_q, state_d;
    logic [7:0]       wait_q, wait_d, wait_inc;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             memop, loaduse, freeze;

    // Memory handshake: DMemReq_o stays high while a load/store sits in MEM; the
    // access completes in the cycle DMemAck_i is high, and that cycle is unfrozen.
    assign memop   = MEMMemRead_i | MEMMemWrite_i;
    assign loaduse = EXMemRead_i && (EXRd_i != 5'd0) &&
                     ((IDUsesRs1_i && (EXRd_i == IDRs1_i)) ||
                      (IDUsesRs2_i && (EXRd_i == IDRs2_i)));
    assign freeze  = !rst_i && memop && !DMemAck_i;

    always_comb begin
        DMemReq_o   = memop;
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
        IFIDFlush_o = 1'b0;
        NoOp_o      = 1'b0;
        Stall_o     = 1'b0;
        if (rst_i) begin
            DMemReq_o   = 1'b0;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            NoOp_o      = 1'b1;
        end else if (freeze) begin
            Stall_o     = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
        end else if (loaduse) begin
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            NoOp_o      = 1'b1;
        end else if (IDBranchTaken_i) begin
            IFIDFlush_o = 1'b1;
        end
    end

    always_comb begin
        state_d   = freeze ? MEMWAIT : RUN;
        wait_inc  = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        wait_d    = 8'd0;
        timeout_d = timeout_q;
        // Timeout fires when the count including this wait cycle reaches MAX_WAIT-1.
        if (state_q == MEMWAIT && freeze) begin
            wait_d = wait_inc;
            if (wait_inc == WAIT_LIM)
                timeout_d = 1'b1;
        end
        stall_cnt_d  = (Stall_o && stall_cnt_q != CNT_MAX) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        bubble_cnt_d = (NoOp_o && bubble_cnt_q != CNT_MAX) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
        flush_cnt_d  = (IFIDFlush_o && flush_cnt_q != CNT_MAX) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            wait_q       <= 8'd0;
            timeout_q    <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            timeout_q    <= timeout_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign Timeout_o     = timeout_q;
    assign StallCycles_o = stall_cnt_q;
    assign BubbleCount_o = bubble_cnt_q;
    assign FlushCount_o  = flush_cnt_q;
    assign FsmState_o    = state_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (MAX_WAIT=4, CNT_W=4).
module tb_hazard_stall_controller;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] IDRs1_i, IDRs2_i, EXRd_i;
  logic       IDUsesRs1_i, IDUsesRs2_i, EXMemRead_i, IDBranchTaken_i;
  logic       MEMMemRead_i, MEMMemWrite_i, DMemAck_i;
  logic       DMemReq_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, NoOp_o, Stall_o, Timeout_o;
  logic [3:0] StallCycles_o, BubbleCount_o, FlushCount_o;
  logic [0:0] FsmState_o;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  hazard_stall_controller #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IDRs1_i(IDRs1_i), .IDRs2_i(IDRs2_i),
    .IDUsesRs1_i(IDUsesRs1_i), .IDUsesRs2_i(IDUsesRs2_i),
    .EXMemRead_i(EXMemRead_i), .EXRd_i(EXRd_i),
    .IDBranchTaken_i(IDBranchTaken_i),
    .MEMMemRead_i(MEMMemRead_i), .MEMMemWrite_i(MEMMemWrite_i), .DMemAck_i(DMemAck_i),
    .DMemReq_o(DMemReq_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o),
    .IFIDFlush_o(IFIDFlush_o), .NoOp_o(NoOp_o), .Stall_o(Stall_o), .Timeout_o(Timeout_o),
    .StallCycles_o(StallCycles_o), .BubbleCount_o(BubbleCount_o), .FlushCount_o(FlushCount_o),
    .FsmState_o(FsmState_o)
  );

  // clock/reset block
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    IDRs1_i = 5'd0; IDRs2_i = 5'd0; EXRd_i = 5'd0;
    IDUsesRs1_i = 1'b0; IDUsesRs2_i = 1'b0; EXMemRead_i = 1'b0;
    IDBranchTaken_i = 1'b0; MEMMemRead_i = 1'b0; MEMMemWrite_i = 1'b0; DMemAck_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic set_loaduse(input logic [4:0] rd, input logic uses2);
    EXMemRead_i = 1'b1; EXRd_i = rd; IDRs2_i = 5'd5; IDUsesRs2_i = uses2;
    IDRs1_i = 5'd9; IDUsesRs1_i = 1'b1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    next_cycle();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    // reset forces outputs even with a pending memory op
    MEMMemRead_i = 1'b1;
    settle();
    check_val("rst_pcwrite", PCWrite_o, 0);
    check_val("rst_noop", NoOp_o, 1);
    check_val("rst_req", DMemReq_o, 0);
    check_val("rst_stall", Stall_o, 0);
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
    idle_inputs();
    settle();
    check_val("rst_state", FsmState_o, 0);
    check_val("rst_timeout", Timeout_o, 0);
    check_val("rst_stallcnt", StallCycles_o, 0);
    check_val("rst_bubblecnt", BubbleCount_o, 0);
    check_val("rst_flushcnt", FlushCount_o, 0);
    check_val("idle_pcwrite", PCWrite_o, 1);

    // load-use bubble
    next_cycle();
    set_loaduse(5'd5, 1'b1);
    settle();
    check_val("lu_pcwrite", PCWrite_o, 0);
    check_val("lu_ifidwrite", IFIDWrite_o, 0);
    check_val("lu_noop", NoOp_o, 1);
    next_cycle();
    idle_inputs();
    settle();
    check_val("lu_bubblecnt", BubbleCount_o, 1);
    check_val("lu_after_noop", NoOp_o, 0);
    next_cycle();
    set_loaduse(5'd0, 1'b1);
    settle();
    check_val("lu_x0_noop", NoOp_o, 0);
    next_cycle();
    set_loaduse(5'd5, 1'b0);
    settle();
    check_val("lu_nouse_noop", NoOp_o, 0);
    check_val("lu_nouse_pcwrite", PCWrite_o, 1);
    next_cycle();
    set_loaduse(5'd9, 1'b0);
    settle();
    check_val("lu_rs1_noop", NoOp_o, 1);

    // branch suppressed by load-use, then taken
    next_cycle();
    set_loaduse(5'd5, 1'b1);
    IDBranchTaken_i = 1'b1;
    settle();
    check_val("br_lu_noop", NoOp_o, 1);
    check_val("br_lu_flush", IFIDFlush_o, 0);
    next_cycle();
    EXMemRead_i = 1'b0;
    settle();
    check_val("br_flush", IFIDFlush_o, 1);
    check_val("br_pcwrite", PCWrite_o, 1);
    check_val("br_noop", NoOp_o, 0);
    next_cycle();
    idle_inputs();
    settle();
    check_val("br_flushcnt", FlushCount_o, 1);
    check_val("br_bubblecnt", BubbleCount_o, 3);

    // memory wait: 3 freeze cycles then ack
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
    next_cycle();
    MEMMemRead_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      DMemAck_i = (i == 3);
      settle();
      check_val("mw_stall", Stall_o, exp_q.pop_front());
      check_val("mw_req", DMemReq_o, 1);
      check_val("mw_pcwrite", PCWrite_o, (i == 3) ? 1 : 0);
      check_val("mw_state", FsmState_o, (i == 0) ? 0 : 1);
      next_cycle();
    end
    idle_inputs();
    settle();
    check_val("mw_stallcnt", StallCycles_o, 3);
    check_val("mw_state_run", FsmState_o, 0);

    // hit: ack with first request
    next_cycle();
    MEMMemWrite_i = 1'b1; DMemAck_i = 1'b1;
    settle();
    check_val("hit_stall", Stall_o, 0);
    check_val("hit_req", DMemReq_o, 1);
    next_cycle();
    idle_inputs();
    settle();
    check_val("hit_state", FsmState_o, 0);
    check_val("hit_stallcnt", StallCycles_o, 3);

    // timeout: 6 freeze cycles, MAX_WAIT=4
    next_cycle();
    MEMMemRead_i = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      settle();
      check_val("to_flag", Timeout_o, (n >= 5) ? 1 : 0);
      check_val("to_stall", Stall_o, 1);
      next_cycle();
    end
    DMemAck_i = 1'b1;
    settle();
    check_val("to_ack_stall", Stall_o, 0);
    check_val("to_ack_flag", Timeout_o, 1);
    next_cycle();
    idle_inputs();
    settle();
    check_val("to_sticky", Timeout_o, 1);
    check_val("to_stallcnt", StallCycles_o, 9);
    check_val("to_state", FsmState_o, 0);

    // memop drops in MEMWAIT without ack
    next_cycle();
    MEMMemWrite_i = 1'b1;
    next_cycle();
    MEMMemWrite_i = 1'b0;
    settle();
    check_val("drop_state", FsmState_o, 1);
    check_val("drop_stall", Stall_o, 0);
    next_cycle();
    settle();
    check_val("drop_run", FsmState_o, 0);

    // reset during MEMWAIT
    next_cycle();
    MEMMemRead_i = 1'b1;
    next_cycle();
    next_cycle();
    settle();
    check_val("rmw_state", FsmState_o, 1);
    next_cycle();
    rst_i = 1'b1;
    settle();
    check_val("rmw_rst_stall", Stall_o, 0);
    check_val("rmw_rst_req", DMemReq_o, 0);
    next_cycle();
    rst_i = 1'b0;
    idle_inputs();
    settle();
    check_val("rmw_state_run", FsmState_o, 0);
    check_val("rmw_timeout", Timeout_o, 0);
    check_val("rmw_stallcnt", StallCycles_o, 0);
    check_val("rmw_flushcnt", FlushCount_o, 0);

    // bubble counter saturation
    do_reset();
    set_loaduse(5'd5, 1'b1);
    for (int k = 0; k < 20; k++) next_cycle();
    idle_inputs();
    settle();
    check_val("sat_bubblecnt", BubbleCount_o, 15);

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL exp_q_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
